// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and constants for the multiplexed seven-segment
//                display path (scheduler state encoding, segment bus width and
//                the all-segments-off pattern for a common-anode display).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Segment bus is {g,f,e,d,c,b,a}; active-low because the display is
    // common anode.
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Scheduler phases: BLANK is dead time with every anode off, DRIVE lights
    // the selected digit for the dwell period.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } mux_state_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/seven_segment.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment
//  Description : Combinational hex-to-seven-segment decoder, active-low
//                outputs for a common-anode display. Lower-case b and d are
//                used so that 8/B and 0/D stay distinguishable.
//  Ports       : nibble [3:0]  in   hex value to display
//                seg    [6:0]  out  {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment
    import display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule : seven_segment
`default_nettype wire

// File: rtl/display_mux_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_mux_ctrl
//  Description : Round-robin time-multiplexing scheduler that shares one
//                seven-segment decoder and one segment bus between DIGITS
//                digit positions. Each slot is BLANK_CYCLES of dead time
//                (all anodes off) followed by DWELL cycles driving one digit.
//  Ports       : clk         in   1         system clock
//                reset       in   1         synchronous, active-high reset
//                digits      in   4*DIGITS  packed hex nibbles, digit i at [4i+3:4i]
//                digit_en    in   DIGITS    per-digit enable (0 = anode stays off)
//                seg         out  7         {g,f,e,d,c,b,a}, active-low
//                an          out  DIGITS    anode enables, active-low
//                cur_digit   out  IDX_W     index of the slot in progress
//                frame_start out  1         pulse on first DRIVE cycle of digit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module display_mux_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int DWELL        = 64,
    parameter int BLANK_CYCLES = 4,
    parameter int IDX_W        = $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] digits,
    input  logic [DIGITS-1:0]   digit_en,
    output logic [SEG_W-1:0]    seg,
    output logic [DIGITS-1:0]   an,
    output logic [IDX_W-1:0]    cur_digit,
    output logic                frame_start
);

    // Counter only ever has to reach the longer of the two phase lengths
    // minus one; the extra +1 keeps the width sane when both are 1.
    localparam int CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(DIGITS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    mux_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_nibble;

    mux_state_t         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_latch;

    logic [SEG_W-1:0]   w_seg_dec;
    logic [SEG_W-1:0]   w_seg_nxt;
    logic [DIGITS-1:0]  w_an_nxt;
    logic               w_frame_nxt;
    logic [3:0]         w_sel_nibble;

    // Digit value for the slot about to be driven; captured once so the
    // segment pattern cannot change while the anode is on.
    assign w_sel_nibble = digits[{r_idx, 2'b00} +: 4];

    seven_segment u_seven_segment (
        .nibble (r_nibble),
        .seg    (w_seg_dec)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // Outputs are computed from the current state and registered, so the
    // pins lag the FSM by one cycle. That lag is what makes the first DRIVE
    // output land exactly BLANK_CYCLES cycles after reset release.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_latch     = 1'b0;
        w_an_nxt    = '1;
        w_seg_nxt   = SEG_OFF;
        w_frame_nxt = 1'b0;

        unique case (r_state)
            BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_nxt = DRIVE;
                    w_cnt_nxt   = '0;
                    w_latch     = 1'b1;
                end
            end

            DRIVE: begin
                // digit_en is honoured live; a disabled digit still burns
                // its slot so the duty cycle of the others is unchanged.
                w_an_nxt[r_idx] = ~digit_en[r_idx];
                if (digit_en[r_idx]) begin
                    w_seg_nxt = w_seg_dec;
                end
                w_frame_nxt = (r_cnt == '0) && (r_idx == '0);

                if (r_cnt == c_dwell_last) begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    // Explicit wrap so non-power-of-two DIGITS never
                    // reaches an unused index.
                    w_idx_nxt   = (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
                end
            end

            default: begin
                w_state_nxt = BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BLANK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_nibble    <= '0;
            seg         <= SEG_OFF;
            an          <= '1;
            cur_digit   <= '0;
            frame_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            if (w_latch) begin
                r_nibble <= w_sel_nibble;
            end
            seg         <= w_seg_nxt;
            an          <= w_an_nxt;
            cur_digit   <= r_idx;
            frame_start <= w_frame_nxt;
        end
    end

endmodule : display_mux_ctrl
`default_nettype wire

// File: tb/tb_display_mux_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_mux_ctrl
//  Description : Self-checking bench for display_mux_ctrl. A cycle-indexed
//                reference model derives the expected pin values from the
//                slot/frame arithmetic (time since reset release), and runs
//                a directed prologue followed by randomized traffic.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_mux_ctrl;

    localparam int DIGITS       = 2;
    localparam int DWELL        = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int IDX_W        = $clog2(DIGITS);
    localparam int SLOT         = BLANK_CYCLES + DWELL;
    localparam int FRAME        = DIGITS * SLOT;

    logic                clk = 1'b0;
    logic                reset;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   digit_en;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic [IDX_W-1:0]    cur_digit;
    logic                frame_start;

    display_mux_ctrl #(
        .DIGITS       (DIGITS),
        .DWELL        (DWELL),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IDX_W        (IDX_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .digits      (digits),
        .digit_en    (digit_en),
        .seg         (seg),
        .an          (an),
        .cur_digit   (cur_digit),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Active-low decode reference for hex 0..F.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int err_cnt = 0;
    int chk_cnt = 0;

    // Model state: cycles since reset release and the value captured for
    // each digit at the start of its most recent slot.
    int         t_rel = 0;
    logic [3:0] nib_m [DIGITS];

    logic [6:0]        prev_seg;
    logic [DIGITS-1:0] prev_an;
    logic              prev_ok = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time=%0t)", tag, obs, exp_v, t_rel, $time);
        end
    endtask

    // Drive one cycle of inputs, let the DUT clock them, then compare the
    // pins with what the slot arithmetic says they must be.
    task automatic step(input logic rst_v, input logic [4*DIGITS-1:0] dig_v,
                        input logic [DIGITS-1:0] en_v);
        logic [6:0]        e_seg;
        logic [DIGITS-1:0] e_an;
        int                e_cur;
        logic              e_fs;
        int                p, d, q;
        reset    = rst_v;
        digits   = dig_v;
        digit_en = en_v;
        @(posedge clk);
        #1;
        e_seg = 7'h7F;
        e_an  = '1;
        e_cur = 0;
        e_fs  = 1'b0;
        if (rst_v) begin
            t_rel = 0;
        end else begin
            t_rel++;
            p = (t_rel - 1) % FRAME;
            d = p / SLOT;
            q = p % SLOT;
            e_cur = d;
            if (q == BLANK_CYCLES - 1) begin
                nib_m[d] = dig_v[4*d +: 4];
            end
            if (q >= BLANK_CYCLES) begin
                e_an[d] = ~en_v[d];
                if (en_v[d]) begin
                    e_seg = seg_tab[nib_m[d]];
                end
                e_fs = (d == 0) && (q == BLANK_CYCLES);
            end
        end
        check_val("seg",         32'(seg),         32'(e_seg));
        check_val("an",          32'(an),          32'(e_an));
        check_val("cur_digit",   32'(cur_digit),   32'(e_cur));
        check_val("frame_start", 32'(frame_start), 32'(e_fs));

        // Structural invariants independent of the model.
        check_val("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        if (prev_ok && (seg !== prev_seg)) begin
            check_val("seg_glitch", 32'((prev_an == '1) || (an == '1)), 32'd1);
        end
        prev_seg = seg;
        prev_an  = an;
        prev_ok  = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        digits   = 8'h30;
        digit_en = 2'b11;
        for (int i = 0; i < DIGITS; i++) nib_m[i] = 4'h0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h30, 2'b11);

        // Basic sequence, with digit 0 changed mid-DRIVE from cycle 4 on.
        for (int c = 1; c <= 26; c++) begin
            step(1'b0, (c >= 4) ? 8'h3F : 8'h30, 2'b11);
        end

        // Digit 1 masked for two full frames.
        for (int c = 0; c < 2 * FRAME; c++) step(1'b0, 8'h5A, 2'b01);

        // Reset asserted mid-DRIVE at cycle 10, then restart.
        step(1'b1, 8'h30, 2'b11);
        for (int c = 1; c <= 9; c++) step(1'b0, 8'h30, 2'b11);
        step(1'b1, 8'h30, 2'b11);
        for (int c = 1; c <= 20; c++) step(1'b0, 8'hC7, 2'b11);

        // Randomized traffic: sparse digit/enable changes and occasional reset.
        begin
            logic [4*DIGITS-1:0] r_dig;
            logic [DIGITS-1:0]   r_en;
            logic                r_rst;
            r_dig = 8'h12;
            r_en  = 2'b11;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 4) == 0) r_dig = 8'($urandom);
                if ($urandom_range(0, 15) == 0) r_en = 2'($urandom);
                r_rst = ($urandom_range(0, 120) == 0);
                step(r_rst, r_dig, r_en);
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_display_mux_ctrl
`default_nettype wire
